// File: rtl/alu_pkg.sv
// Shared op codes and helpers for the pipelined ALU.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD   = 3'd0;
  localparam op_t OP_AND   = 3'd1;
  localparam op_t OP_NOT   = 3'd2;
  localparam op_t OP_SUB   = 3'd3;
  localparam op_t OP_OR    = 3'd4;
  localparam op_t OP_XOR   = 3'd5;
  localparam op_t OP_SLT   = 3'd6;
  localparam op_t OP_PASSB = 3'd7;

  // Ops that go through the adder and report a carry.
  function automatic logic is_arith(op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Ops that subtract: b is inverted and the low-half carry-in is 1.
  function automatic logic is_subtract(op_t op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/pipelined_alu_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface pipelined_alu_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_pkg::op_t     op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             negative;
  logic             overflow;

  // Producer/consumer side of the ALU.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry_out, zero, negative, overflow
  );

  // The ALU itself.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry_out, zero, negative, overflow
  );

endinterface

// File: rtl/alu_slice.sv
// Combinational W-bit ALU slice; chained low/high to form the full-width datapath.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_t          op,
  input  logic         c_in,
  output logic [W-1:0] y,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  // Adder with optional b inversion, plus the logic-op mux.
  always_comb begin
    b_eff    = is_subtract(op) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + (W+1)'(c_in);
    c_out    = sum[W];
    c_msb_in = a[W-1] ^ b_eff[W-1] ^ sum[W-1];
    case (op)
      OP_AND:   y = a & b;
      OP_NOT:   y = ~a;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_PASSB: y = b;
      default:  y = sum[W-1:0];
    endcase
  end

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage ALU: low half of the carry chain in stage 1, high half and flags in stage 2.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  pipelined_alu_if.slave bus
);

  localparam int unsigned HALF = WIDTH / 2;

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("pipelined_alu: WIDTH must be even and >= 4");
  end

  logic            advance;
  logic            lo_c_in;
  logic [HALF-1:0] lo_y;
  logic            lo_c;
  logic            lo_msb_unused;

  logic            s1_valid;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;
  logic [HALF-1:0] s1_lo;
  op_t             s1_op;
  logic            s1_c_mid;

  logic [HALF-1:0] hi_y;
  logic            hi_c;
  logic            hi_msb_in;
  logic            hi_ovf;
  logic [WIDTH-1:0] res_next;
  logic            carry_next;
  logic            ovf_next;

  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             zero_reg;
  logic             negative_reg;
  logic             overflow_reg;

  // Global stall: the whole pipe moves only when the output slot frees up.
  always_comb begin
    advance = !reset && (!out_valid_reg || bus.out_ready);
    lo_c_in = is_subtract(bus.op);
  end

  assign bus.in_ready = advance;

  alu_slice #(.W(HALF)) u_lo (
    .a        (bus.a[HALF-1:0]),
    .b        (bus.b[HALF-1:0]),
    .op       (bus.op),
    .c_in     (lo_c_in),
    .y        (lo_y),
    .c_out    (lo_c),
    .c_msb_in (lo_msb_unused)
  );

  // Stage 1: low-half result, mid carry and the high operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_lo    <= '0;
      s1_op    <= OP_ADD;
      s1_c_mid <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_hi  <= bus.a[WIDTH-1:HALF];
        s1_b_hi  <= bus.b[WIDTH-1:HALF];
        s1_lo    <= lo_y;
        s1_op    <= bus.op;
        s1_c_mid <= lo_c;
      end
    end
  end

  alu_slice #(.W(HALF)) u_hi (
    .a        (s1_a_hi),
    .b        (s1_b_hi),
    .op       (s1_op),
    .c_in     (s1_c_mid),
    .y        (hi_y),
    .c_out    (hi_c),
    .c_msb_in (hi_msb_in)
  );

  // Stage 2 combine: full result, SLT from the subtraction sign, carry/overflow flags.
  always_comb begin
    hi_ovf     = hi_msb_in ^ hi_c;
    res_next   = {hi_y, s1_lo};
    if (s1_op == OP_SLT) begin
      res_next = WIDTH'(hi_y[HALF-1] ^ hi_ovf);
    end
    carry_next = is_arith(s1_op) && hi_c;
    ovf_next   = ((s1_op == OP_ADD) || (s1_op == OP_SUB)) && hi_ovf;
  end

  // Stage 2 registers: result and flags, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      negative_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= s1_valid;
      if (s1_valid) begin
        result_reg   <= res_next;
        carry_reg    <= carry_next;
        zero_reg     <= (res_next == '0);
        negative_reg <= res_next[WIDTH-1];
        overflow_reg <= ovf_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.carry_out = carry_reg;
  assign bus.zero      = zero_reg;
  assign bus.negative  = negative_reg;
  assign bus.overflow  = overflow_reg;

endmodule
